// File: rtl/core_pkg.sv
// Shared core definitions: opcodes, ALU operation encodings and the
// decoded control bundle carried down the pipeline.
package core_pkg;

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_BEQ   = 7'b1100011;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

  typedef struct packed {
    logic       branch;
    logic       mem_read;
    logic       mem_to_reg;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic [1:0] alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{branch: 1'b0, mem_read: 1'b0, mem_to_reg: 1'b0,
                                 mem_write: 1'b0, alu_src: 1'b0, reg_write: 1'b0,
                                 alu_op: 2'b00};

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection against the instruction in EX, plus the
// PC / IF-ID write enables; a flush always lets the front end move.
module hazard_detect (
  input  logic       ex_valid,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       id_valid,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       flush,
  output logic       hazard,
  output logic       pc_write,
  output logic       if_id_write
);

  logic rd_match_s;

  // Both source indices are compared whatever the instruction format.
  always_comb begin
    rd_match_s  = (ex_rd != 5'd0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
    hazard      = ex_valid & ex_mem_read & id_valid & rd_match_s;
    pc_write    = ~hazard | flush;
    if_id_write = ~hazard | flush;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush squash
// and saturating stall/flush event counters.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7_b5,
  input  logic             id_branch,
  input  logic             id_mem_read,
  input  logic             id_mem_to_reg,
  input  logic             id_mem_write,
  input  logic             id_alu_src,
  input  logic             id_reg_write,
  input  logic [1:0]       id_alu_op,
  input  logic             flush,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7_b5,
  output logic             ex_branch,
  output logic             ex_mem_read,
  output logic             ex_mem_to_reg,
  output logic             ex_mem_write,
  output logic             ex_alu_src,
  output logic             ex_reg_write,
  output logic [1:0]       ex_alu_op,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic            funct7_b5;
  } data_t;

  logic            hazard_s;
  logic            valid_d, valid_q;
  ctrl_t           ctrl_d, ctrl_q;
  data_t           data_d, data_q;
  logic [CNT_W-1:0] stall_cnt_d, stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_d, flush_cnt_q;

  hazard_detect u_hazard_detect (
    .ex_valid    (valid_q),
    .ex_mem_read (ctrl_q.mem_read),
    .ex_rd       (data_q.rd),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .flush       (flush),
    .hazard      (hazard_s),
    .pc_write    (pc_write),
    .if_id_write (if_id_write)
  );

  // Next-state: data always loads; a bubble or an empty slot clears valid and control.
  always_comb begin
    data_d = '{pc: id_pc, rs1_data: id_rs1_data, rs2_data: id_rs2_data, imm: id_imm,
               rs1: id_rs1, rs2: id_rs2, rd: id_rd, funct3: id_funct3,
               funct7_b5: id_funct7_b5};
    valid_d = id_valid;
    ctrl_d  = '{branch: id_branch, mem_read: id_mem_read, mem_to_reg: id_mem_to_reg,
                mem_write: id_mem_write, alu_src: id_alu_src, reg_write: id_reg_write,
                alu_op: id_alu_op};
    if (flush || hazard_s || !id_valid) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_NOP;
    end else begin
      valid_d = 1'b1;
    end

    stall_cnt_d = stall_cnt_q;
    if (hazard_s && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_d = stall_cnt_q;
    end

    flush_cnt_d = flush_cnt_q;
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) begin
      flush_cnt_d = flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      flush_cnt_d = flush_cnt_q;
    end
  end

  // Stage register and counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      ctrl_q      <= CTRL_NOP;
      data_q      <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      valid_q     <= valid_d;
      ctrl_q      <= ctrl_d;
      data_q      <= data_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign ex_valid      = valid_q;
  assign ex_pc         = data_q.pc;
  assign ex_rs1_data   = data_q.rs1_data;
  assign ex_rs2_data   = data_q.rs2_data;
  assign ex_imm        = data_q.imm;
  assign ex_rs1        = data_q.rs1;
  assign ex_rs2        = data_q.rs2;
  assign ex_rd         = data_q.rd;
  assign ex_funct3     = data_q.funct3;
  assign ex_funct7_b5  = data_q.funct7_b5;
  assign ex_branch     = ctrl_q.branch;
  assign ex_mem_read   = ctrl_q.mem_read;
  assign ex_mem_to_reg = ctrl_q.mem_to_reg;
  assign ex_mem_write  = ctrl_q.mem_write;
  assign ex_alu_src    = ctrl_q.alu_src;
  assign ex_reg_write  = ctrl_q.reg_write;
  assign ex_alu_op     = ctrl_q.alu_op;
  assign stall_cnt     = stall_cnt_q;
  assign flush_cnt     = flush_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: a 16-bit-counter instance and a 2-bit-counter
// instance share the same stimulus.
module tb_id_ex_stage;
  import core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid, id_funct7_b5, flush;
  logic [63:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic        id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write;
  logic [1:0]  id_alu_op;

  logic        pc_write, if_id_write, ex_valid, ex_funct7_b5;
  logic [63:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic        ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write;
  logic [1:0]  ex_alu_op;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_if_id_write, s_ex_valid, s_ex_funct7_b5;
  logic [63:0] s_ex_pc, s_ex_rs1_data, s_ex_rs2_data, s_ex_imm;
  logic [4:0]  s_ex_rs1, s_ex_rs2, s_ex_rd;
  logic [2:0]  s_ex_funct3;
  logic        s_ex_branch, s_ex_mem_read, s_ex_mem_to_reg, s_ex_mem_write, s_ex_alu_src, s_ex_reg_write;
  logic [1:0]  s_ex_alu_op;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(64), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7_b5(id_funct7_b5), .id_branch(id_branch), .id_mem_read(id_mem_read),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_alu_op(id_alu_op), .flush(flush),
    .pc_write(pc_write), .if_id_write(if_id_write), .ex_valid(ex_valid), .ex_pc(ex_pc),
    .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_funct3(ex_funct3),
    .ex_funct7_b5(ex_funct7_b5), .ex_branch(ex_branch), .ex_mem_read(ex_mem_read),
    .ex_mem_to_reg(ex_mem_to_reg), .ex_mem_write(ex_mem_write), .ex_alu_src(ex_alu_src),
    .ex_reg_write(ex_reg_write), .ex_alu_op(ex_alu_op),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  id_ex_stage #(.XLEN(64), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7_b5(id_funct7_b5), .id_branch(id_branch), .id_mem_read(id_mem_read),
    .id_mem_to_reg(id_mem_to_reg), .id_mem_write(id_mem_write), .id_alu_src(id_alu_src),
    .id_reg_write(id_reg_write), .id_alu_op(id_alu_op), .flush(flush),
    .pc_write(s_pc_write), .if_id_write(s_if_id_write), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc),
    .ex_rs1_data(s_ex_rs1_data), .ex_rs2_data(s_ex_rs2_data), .ex_imm(s_ex_imm),
    .ex_rs1(s_ex_rs1), .ex_rs2(s_ex_rs2), .ex_rd(s_ex_rd), .ex_funct3(s_ex_funct3),
    .ex_funct7_b5(s_ex_funct7_b5), .ex_branch(s_ex_branch), .ex_mem_read(s_ex_mem_read),
    .ex_mem_to_reg(s_ex_mem_to_reg), .ex_mem_write(s_ex_mem_write), .ex_alu_src(s_ex_alu_src),
    .ex_reg_write(s_ex_reg_write), .ex_alu_op(s_ex_alu_op),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Data fields are derived from the indices so expected values are easy to state.
  task automatic drive(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input ctrl_t c);
    id_valid      = v;
    id_rs1        = rs1;
    id_rs2        = rs2;
    id_rd         = rd;
    id_pc         = 64'h1000 + {59'd0, rd};
    id_rs1_data   = 64'hA000 + {59'd0, rs1};
    id_rs2_data   = 64'hB000 + {59'd0, rs2};
    id_imm        = 64'hFFFF_FFFF_FFFF_FFF0 | {59'd0, rd};
    id_funct3     = rd[2:0];
    id_funct7_b5  = rd[0];
    id_branch     = c.branch;
    id_mem_read   = c.mem_read;
    id_mem_to_reg = c.mem_to_reg;
    id_mem_write  = c.mem_write;
    id_alu_src    = c.alu_src;
    id_reg_write  = c.reg_write;
    id_alu_op     = c.alu_op;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, ".valid"}, {63'd0, ex_valid}, 64'd0);
    chk({tag, ".ctrl"}, {56'd0, ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write,
                         ex_alu_src, ex_reg_write, ex_alu_op}, 64'd0);
  endtask

  ctrl_t c_add, c_ld;

  initial begin
    c_add = '{branch: 1'b0, mem_read: 1'b0, mem_to_reg: 1'b0, mem_write: 1'b0,
              alu_src: 1'b0, reg_write: 1'b1, alu_op: ALU_OP_FUNCT};
    c_ld  = '{branch: 1'b0, mem_read: 1'b1, mem_to_reg: 1'b1, mem_write: 1'b0,
              alu_src: 1'b1, reg_write: 1'b1, alu_op: ALU_OP_ADD};
    rst_n = 1'b0;
    flush = 1'b0;
    drive(1'b0, 5'd0, 5'd0, 5'd0, CTRL_NOP);
    #2;
    chk("por.valid", {63'd0, ex_valid}, 64'd0);
    chk("por.pc_write", {63'd0, pc_write}, 64'd1);
    chk("por.stall_cnt", {48'd0, stall_cnt}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Normal flow: add x5, x1, x2
    drive(1'b1, 5'd1, 5'd2, 5'd5, c_add);
    tick();
    chk("add.valid", {63'd0, ex_valid}, 64'd1);
    chk("add.reg_write", {63'd0, ex_reg_write}, 64'd1);
    chk("add.alu_op", {62'd0, ex_alu_op}, 64'd2);
    chk("add.rd", {59'd0, ex_rd}, 64'd5);
    chk("add.pc", ex_pc, 64'h1005);
    chk("add.rs2_data", ex_rs2_data, 64'hB002);
    chk("add.imm", ex_imm, 64'hFFFF_FFFF_FFFF_FFF5);
    chk("add.funct", {60'd0, ex_funct3, ex_funct7_b5}, 64'hB);

    // Load-use via rs1: ld x5 then add x6, x5, x7
    drive(1'b1, 5'd10, 5'd0, 5'd5, c_ld);
    tick();
    drive(1'b1, 5'd5, 5'd7, 5'd6, c_add);
    #1;
    chk("lu.pc_write", {63'd0, pc_write}, 64'd0);
    chk("lu.if_id_write", {63'd0, if_id_write}, 64'd0);
    tick();
    chk_bubble("lu.bubble");
    chk("lu.bubble.rd", {59'd0, ex_rd}, 64'd6);
    chk("lu.stall_cnt", {48'd0, stall_cnt}, 64'd1);
    chk("lu.release.pc_write", {63'd0, pc_write}, 64'd1);
    tick();
    chk("lu.load.valid", {63'd0, ex_valid}, 64'd1);
    chk("lu.load.reg_write", {63'd0, ex_reg_write}, 64'd1);
    chk("lu.load.stall_cnt", {48'd0, stall_cnt}, 64'd1);

    // No false hazard: ld x0 then a reader of x0
    drive(1'b1, 5'd10, 5'd0, 5'd0, c_ld);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd8, c_add);
    #1;
    chk("x0.pc_write", {63'd0, pc_write}, 64'd1);
    // ld x5 then a reader of x3/x4
    drive(1'b1, 5'd10, 5'd0, 5'd5, c_ld);
    tick();
    drive(1'b1, 5'd3, 5'd4, 5'd9, c_add);
    #1;
    chk("nomatch.pc_write", {63'd0, pc_write}, 64'd1);
    tick();
    chk("nomatch.valid", {63'd0, ex_valid}, 64'd1);
    chk("nomatch.stall_cnt", {48'd0, stall_cnt}, 64'd1);

    // Load-use via rs2
    drive(1'b1, 5'd10, 5'd0, 5'd5, c_ld);
    tick();
    drive(1'b1, 5'd3, 5'd5, 5'd9, c_add);
    #1;
    chk("rs2.if_id_write", {63'd0, if_id_write}, 64'd0);
    tick();
    chk_bubble("rs2.bubble");
    chk("rs2.stall_cnt", {48'd0, stall_cnt}, 64'd2);
    tick();

    // Flush with a simultaneous hazard
    drive(1'b1, 5'd10, 5'd0, 5'd5, c_ld);
    tick();
    drive(1'b1, 5'd5, 5'd0, 5'd6, c_add);
    flush = 1'b1;
    #1;
    chk("flush.pc_write", {63'd0, pc_write}, 64'd1);
    tick();
    flush = 1'b0;
    chk_bubble("flush.bubble");
    chk("flush.flush_cnt", {48'd0, flush_cnt}, 64'd1);
    chk("flush.stall_cnt", {48'd0, stall_cnt}, 64'd2);
    chk("flush.sat.flush_cnt", {62'd0, s_flush_cnt}, 64'd1);

    // Invalid slot carrying write-enables
    drive(1'b0, 5'd1, 5'd2, 5'd12, c_add);
    tick();
    chk_bubble("inv");
    chk("inv.rd", {59'd0, ex_rd}, 64'd12);

    // Chain of five dependent loads, each costing one bubble
    drive(1'b1, 5'd10, 5'd0, 5'd5, c_ld);
    tick();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'd5 + 5'(i), 5'd0, 5'd6 + 5'(i), c_ld);
      #1;
      chk("chain.pc_write", {63'd0, pc_write}, 64'd0);
      tick();
      chk("chain.stall_cnt", {48'd0, stall_cnt}, 64'd3 + 64'(i));
      chk("chain.sat.stall_cnt", {62'd0, s_stall_cnt}, 64'd3);
      tick();
    end

    // Asynchronous reset mid-stall, with ex_reg_write = 1 (ld x10 in EX)
    drive(1'b1, 5'd10, 5'd0, 5'd11, c_add);
    #1;
    chk("rst.pre.reg_write", {63'd0, ex_reg_write}, 64'd1);
    chk("rst.pre.pc_write", {63'd0, pc_write}, 64'd0);
    rst_n = 1'b0;
    #1;
    chk("rst.valid", {63'd0, ex_valid}, 64'd0);
    chk("rst.reg_write", {63'd0, ex_reg_write}, 64'd0);
    chk("rst.mem_read", {63'd0, ex_mem_read}, 64'd0);
    chk("rst.rd", {59'd0, ex_rd}, 64'd0);
    chk("rst.pc", ex_pc, 64'd0);
    chk("rst.stall_cnt", {48'd0, stall_cnt}, 64'd0);
    chk("rst.flush_cnt", {48'd0, flush_cnt}, 64'd0);
    chk("rst.pc_write", {63'd0, pc_write}, 64'd1);
    chk("rst.if_id_write", {63'd0, if_id_write}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst.valid", {63'd0, ex_valid}, 64'd1);
    chk("post_rst.rd", {59'd0, ex_rd}, 64'd11);
    chk("post_rst.stall_cnt", {48'd0, stall_cnt}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage for the five-stage RISC-V core. It captures the decoded control bundle, register-file read data, immediate and register indices from the decode stage. It detects load-use hazards against the instruction currently in EX and inserts a one-cycle bubble when one is found. It zeroes the control bundle on a branch flush. It also keeps saturating counters of stalls and flushes for debug.

## Interface
- XLEN, 64, datapath width (pc, register data, immediate)
- CNT_W, 16, width of the stall and flush counters
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low; one clock, no other reset
- id_valid  in  1  decode slot holds a real instruction
- id_pc, id_rs1_data, id_rs2_data, id_imm  in  XLEN  decode-stage values
- id_rs1, id_rs2, id_rd  in  5  register indices
- id_funct3  in  3; id_funct7_b5  in  1  (instr[30]), forwarded for ALU control
- id_branch, id_mem_read, id_mem_to_reg, id_mem_write, id_alu_src, id_reg_write  in  1  control bundle from the decoder
- id_alu_op  in  2  control bundle from the decoder
- flush  in  1  branch resolved taken downstream; squash the decode slot
- pc_write  out  1  0 freezes the PC (combinational)
- if_id_write  out  1  0 freezes the IF/ID register (combinational)
- ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7_b5  out  registered copies of the id_* data fields
- ex_branch, ex_mem_read, ex_mem_to_reg, ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op  out  registered control bundle
- stall_cnt, flush_cnt  out  CNT_W  saturating event counters

## Operation
- Hazard (combinational): `hazard = ex_valid & ex_mem_read & id_valid & (ex_rd != 0) & (ex_rd == id_rs1 | ex_rd == id_rs2)`.
  - Both rs1 and rs2 are compared regardless of instruction type.
- Outputs: `pc_write = if_id_write = ~hazard | flush`.
  - Flush overrides stall, so the PC is free to take the branch target.
- Register update priority on each posedge, highest first:
  - 1. flush: bubble.
  - 2. hazard: bubble.
  - 3. Otherwise: normal load. All ex_* take their id_* values; ex_valid = id_valid.
- Bubble:
  - ex_valid = 0.
  - All seven control outputs = 0 (ex_alu_op = 00).
  - Data fields (pc, rs*_data, imm, indices, funct) still load their id_* values; they are don't-care downstream.
- id_valid = 0 with no flush or hazard: fields load normally, ex_valid = 0.
  - The control bundle is also forced to 0, so an invalid slot never writes.
- stall_cnt increments on each cycle with hazard & ~flush. flush_cnt increments on each cycle with flush. Both saturate at 2^CNT_W−1.
- Reset (rst_n low, asynchronous):
  - Every ex_* output = 0, stall_cnt = flush_cnt = 0.
  - pc_write = if_id_write = 1, since ex_valid = 0 makes hazard = 0.
- Reset mid-stall: the bubble and counters clear immediately. After release, the next edge loads normally.

## Timing
- Latency: one cycle, id_* to ex_*.
- A load-use stall lasts exactly one cycle. The bubble leaves ex_mem_read = 0, so hazard drops the following cycle and the held instruction loads on the next edge.
- Back-to-back loads feeding each other each cost one bubble.
- flush and hazard in the same cycle: bubble, flush_cnt +1, stall_cnt unchanged, pc_write = 1.
- No combinational path from ex_* registers to ex_* outputs. The only combinational outputs are pc_write and if_id_write, which depend on ex_* registers and id_rs1, id_rs2, id_valid, flush.

## Structure
- Shared package `core_pkg`:
  - The opcode constants (R-type 0110011, load 0000011, store 0100011, beq 1100011).
  - The ALU_OP encodings (00 add, 01 sub, 10 funct-decoded).
  - A `ctrl_t` struct for the seven-signal control bundle, with a `CTRL_NOP` zero constant.
- One sub-module: `hazard_detect`, holding the purely combinational hazard equation and the pc_write / if_id_write drive.
- The stage register and counters live in `id_ex_stage`.

## Test plan
- Reset: assert rst_n = 0 mid-run with ex_reg_write = 1 → all ex_* = 0, counters = 0, and pc_write = 1 before the next clk edge.
- Normal flow: R-type add, rd = 5, rs1 = 1, rs2 = 2, alu_op = 10 → one cycle later ex_reg_write = 1, ex_alu_op = 10, ex_rd = 5, ex_valid = 1.
- Load-use: ld x5 is in EX, decode holds add x6, x5, x7.
  - Same cycle: pc_write = if_id_write = 0.
  - Next edge: bubble, all control = 0, stall_cnt = 1.
  - Following edge: the add is loaded and pc_write = 1.
- No false hazard:
  - ld x0 in EX, decode rs1 = 0 → no stall.
  - ld x5 in EX, decode rs1 = 3, rs2 = 4 → no stall.
- Flush with simultaneous hazard: ld x5 in EX, decode reads x5, flush = 1 → pc_write = 1, bubble, flush_cnt = 1, stall_cnt = 0.
- Saturation: with CNT_W = 2, force 5 consecutive load-use stalls → stall_cnt holds at 3.
